// File: rtl/mc_alu_pkg.sv
// Shared opcode constants, FSM state encoding and engine mode for the mc_alu block.
package mc_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mc_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle over WIDTH cycles.
// done is high in the final iteration; lo/hi then carry the finished result for capture by the top.
module mc_alu_muldiv
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic             busy_q, busy_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    // hi:lo is the running product (mul) or remainder:dividend/quotient (div)
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opnd_q};
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    if (mode_q == MD_DIV) begin
      hi_step = div_ge ? div_diff : div_sh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    busy_d = busy_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (start) begin
      busy_d = 1'b1;
      mode_d = mode;
      cnt_d  = WIDTH'(WIDTH - 1);
      hi_d   = '0;
      lo_d   = a;
      opnd_d = b;
    end else if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - WIDTH'(1);
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign lo   = lo_step;
  assign hi   = hi_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mode_q <= MD_MUL;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      busy_q <= busy_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: FSM, single-cycle datapath and output registers.
// The mul/div engine exists only when ALU_MULDIV_EN is defined; otherwise MULU/DIVU are illegal ops.
//   state   | meaning
//   IDLE    | in_ready=1, waiting for an operation
//   EXEC    | mul/div engine iterating (WIDTH cycles)
//   DONE    | out_valid=1, outputs held until out_ready
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

`ifdef ALU_MULDIV_EN
  logic             md_start;
  logic             md_mode;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .mode  (md_mode),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef ALU_MULDIV_EN
    md_start = 1'b0;
    md_mode  = MD_MUL;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d  = ST_DONE;
          result_d = '0;
          hi_d     = '0;
          err_d    = 1'b0;
          case (op)
            OP_ADD:  result_d = a + b;
            OP_SUB:  result_d = a - b;
            OP_LUI:  result_d = {a[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_OR:   result_d = a | b;
            OP_PASS: result_d = a;
            OP_AND:  result_d = a & b;
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MULDIV_EN
            OP_MULU: begin
              state_d  = ST_EXEC;
              md_start = 1'b1;
              md_mode  = MD_MUL;
            end
            OP_DIVU: begin
              // divide-by-zero short-circuits straight to DONE
              if (b == '0) begin
                result_d = '1;
                hi_d     = a;
                err_d    = 1'b1;
              end else begin
                state_d  = ST_EXEC;
                md_start = 1'b1;
                md_mode  = MD_DIV;
              end
            end
`endif
            default: err_d = 1'b1;
          endcase
          zero_d = (result_d == '0);
        end
      end
      ST_EXEC: begin
`ifdef ALU_MULDIV_EN
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_lo;
          hi_d     = md_hi;
          zero_d   = (md_lo == '0);
          err_d    = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed-vector bench for mc_alu (WIDTH=32); mul/div expectations follow ALU_MULDIV_EN.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        err;

  int total = 0;
  int bad   = 0;

  mc_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // present one op, return cycles from accept edge until out_valid (1 = next cycle)
  task automatic run_op(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("back_to_idle", {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  task automatic expect_op(input string tag, input logic [3:0] o, input logic [31:0] aa,
                           input logic [31:0] bb, input int exp_lat, input logic [31:0] exp_res,
                           input logic [31:0] exp_hi, input logic exp_zero, input logic exp_err);
    int lat;
    run_op(o, aa, bb, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result), 64'(exp_res));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_flags"}, {62'd0, zero, err}, {62'd0, exp_zero, exp_err});
    take();
  endtask

  initial begin
    int stale;
    int lat;
    #23;
    chk("rst_outputs", {out_valid, in_ready, zero, err, result, hi[27:0]}, {4'b0100, 32'd0, 28'd0});
    @(negedge clk); rst_n = 1'b1;

    expect_op("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 32'h0, 1'b1, 1'b0);
    expect_op("sub", 4'b0010, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);
    expect_op("lui", 4'b0011, 32'h1234_ABCD, 32'h5555_5555, 1, 32'hABCD_0000, 32'h0, 1'b0, 1'b0);
    expect_op("or", 4'b0100, 32'hF0F0_0000, 32'h0000_0F0F, 1, 32'hF0F0_0F0F, 32'h0, 1'b0, 1'b0);
    expect_op("pass", 4'b0101, 32'hDEAD_BEEF, 32'h1, 1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    expect_op("and", 4'b0110, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'h0F00_0F00, 32'h0, 1'b0, 1'b0);
    expect_op("sltu_lt", 4'b0111, 32'd3, 32'd5, 1, 32'd1, 32'h0, 1'b0, 1'b0);
    expect_op("sltu_ge", 4'b0111, 32'd5, 32'd3, 1, 32'd0, 32'h0, 1'b1, 1'b0);
    expect_op("sltu_uns", 4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'h0, 1'b1, 1'b0);
    expect_op("ill_0000", 4'b0000, 32'd9, 32'd9, 1, 32'd0, 32'h0, 1'b1, 1'b1);
    expect_op("ill_1111", 4'b1111, 32'd9, 32'd9, 1, 32'd0, 32'h0, 1'b1, 1'b1);

`ifdef ALU_MULDIV_EN
    expect_op("mulu_16", 4'b1000, 32'h1_0000, 32'h1_0000, 33, 32'h0, 32'h1, 1'b1, 1'b0);
    expect_op("mulu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    expect_op("divu_100_7", 4'b1001, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);
    expect_op("divu_big", 4'b1001, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
    expect_op("divu_by0", 4'b1001, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1);
`else
    expect_op("mulu_off", 4'b1000, 32'h1_0000, 32'h1_0000, 1, 32'h0, 32'h0, 1'b1, 1'b1);
    expect_op("divu_off", 4'b1001, 32'd5, 32'd0, 1, 32'h0, 32'h0, 1'b1, 1'b1);
`endif

    // hold in DONE with out_ready low while a new request is offered
    run_op(4'b0001, 32'd7, 32'd8, lat);
    chk("hold_lat", 64'(lat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_state", {29'd0, out_valid, in_ready, zero, err, result}, {29'd0, 4'b1000, 32'd15});
    end
    in_valid = 1'b0;
    take();
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_no_ghost", 64'(out_valid), 64'd0);
    end

    // reset in the middle of an operation
    @(negedge clk);
`ifdef ALU_MULDIV_EN
    op = 4'b1000; a = 32'h1_0000; b = 32'h1_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
`else
    op = 4'b0001; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {out_valid, zero, err, result, hi[28:0]}, {3'b000, 32'd0, 29'd0});
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    expect_op("sub_after_rst", 4'b0010, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
